// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register map, status
// bit layout and the drop-counter saturating increment.
package dmem_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

  typedef enum logic [1:0] {
    MMIO_CON_TX     = 2'd0,
    MMIO_CON_STATUS = 2'd1,
    MMIO_SCRATCH    = 2'd2,
    MMIO_DROP_CNT   = 2'd3
  } mmio_off_e;

  localparam int CON_ST_FULL    = 0;
  localparam int CON_ST_EMPTY   = 1;
  localparam int CON_ST_CNT_LSB = 8;

  localparam int DROP_W = 16;

  function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory bus plus console byte stream between the core side (master)
// and the memory/MMIO responder (slave).
interface dmem_responder_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_rdata;
  logic [7:0]      con_data;
  logic            con_valid;
  logic            con_ready;
  logic            bus_err;

  modport master (
    output dmem_addr, dmem_wdata, dmem_we, con_ready,
    input  dmem_rdata, con_data, con_valid, bus_err
  );

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_we, con_ready,
    output dmem_rdata, con_data, con_valid, bus_err
  );
endinterface

// File: rtl/dmem_responder_sync_fifo.sv
// Circular-buffer FIFO with occupancy count; a push into a full FIFO is only
// accepted when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    // Power-of-two depth lets the pointers wrap by plain overflow.
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    rdata    = empty ? '0 : mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, MMIO window (console TX FIFO, status,
// scratch, drop counter) and a sticky bus-error flag for unmapped accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              MEM_WORDS  = 1024,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [XLEN-1:0] MMIO_BASE  = XLEN'(MMIO_BASE_DEFAULT)
) (
  input logic              clk,
  input logic              reset,
  dmem_responder_if.slave  bus
);

  localparam int RAM_AW = $clog2(MEM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0]   ram_q [MEM_WORDS];
  logic [XLEN-1:0]   scratch_q, scratch_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              bus_err_q, bus_err_d;

  logic              ram_hit, mmio_hit, unmapped;
  mmio_off_e         off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr, ram_we, tx_push, pop, drop;
  logic [7:0]        fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [XLEN-1:0]   status, rdata;
  logic              unused_addr_lo;

  assign unused_addr_lo = ^bus.dmem_addr[1:0];

  always_comb begin
    ram_hit  = (bus.dmem_addr[XLEN-1:RAM_AW+2] == '0);
    mmio_hit = ~ram_hit & (bus.dmem_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4]);
    unmapped = ~ram_hit & ~mmio_hit;
    off      = mmio_off_e'(bus.dmem_addr[3:2]);
    ram_idx  = bus.dmem_addr[RAM_AW+1:2];

    // Writes are squashed while reset is held low.
    wr       = bus.dmem_we & reset;
    ram_we   = wr & ram_hit;
    tx_push  = wr & mmio_hit & (off == MMIO_CON_TX);
    pop      = ~fifo_empty & bus.con_ready;
    drop     = tx_push & fifo_full & ~pop;

    scratch_d = scratch_q;
    if (wr && mmio_hit && off == MMIO_SCRATCH) scratch_d = bus.dmem_wdata;

    drop_d = drop_q;
    if (wr && mmio_hit && off == MMIO_DROP_CNT) drop_d = '0;
    else if (drop)                              drop_d = drop_sat_inc(drop_q);

    bus_err_d = bus_err_q | unmapped;
  end

  always_comb begin
    status                              = '0;
    status[CON_ST_FULL]                 = fifo_full;
    status[CON_ST_EMPTY]                = fifo_empty;
    status[CON_ST_CNT_LSB +: CW]        = fifo_count;

    rdata = '0;
    if (!reset) begin
      rdata = '0;
    end else if (ram_hit) begin
      rdata = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (off)
        MMIO_CON_TX:     rdata = '0;
        MMIO_CON_STATUS: rdata = status;
        MMIO_SCRATCH:    rdata = scratch_q;
        MMIO_DROP_CNT:   rdata = XLEN'(drop_q);
        default:         rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scratch_q <= '0;
      drop_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      drop_q    <= drop_d;
      bus_err_q <= bus_err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= bus.dmem_wdata;
  end

  sync_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (pop),
    .wdata (bus.dmem_wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.dmem_rdata = rdata;
  assign bus.con_data   = fifo_rdata;
  assign bus.con_valid  = ~fifo_empty;
  assign bus.bus_err    = bus_err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's data-memory port: services `dmem_addr`/`dmem_wdata`/`dmem_we` from the datapath and returns `dmem_rdata` in the same cycle. It contains the data RAM and a small MMIO window exposing a console transmit FIFO, a scratch register and a dropped-byte counter. The console FIFO drains through a valid/ready byte stream toward an external sink, for example a UART or the simulation console. It sits beside the core at top level, on the opposite side of the dmem interface from the datapath.

## Interface
Parameters:
- `XLEN`, 32, bus data/address width.
- `MEM_WORDS`, 1024, RAM depth in words; must be a power of 2.
- `FIFO_DEPTH`, 8, console FIFO entries; must be a power of 2 and at least 2.
- `MMIO_BASE`, 32'h1000_0000, byte base of the 16-byte MMIO window.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. Assertion is immediate; release is synchronous to `clk` at top level.
- `dmem_addr` in XLEN: byte address. `[1:0]` is ignored; all accesses are whole words.
- `dmem_wdata` in XLEN: write data, already lane-positioned by the core.
- `dmem_we` in 1: write strobe, sampled at the rising edge.
- `dmem_rdata` out XLEN: combinational read data.
- `con_data` out 8: FIFO head byte.
- `con_valid` out 1: FIFO non-empty.
- `con_ready` in 1: sink accepts `con_data` this cycle.
- `bus_err` out 1: sticky flag, set by any access outside RAM and MMIO.

## Operation
Address decode:
- RAM: `dmem_addr < MEM_WORDS*4`.
- MMIO: `dmem_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4]`.
- Anything else: unmapped.

RAM behaviour:
- Asynchronous read.
- Synchronous word write when `dmem_we` is high.
- Contents are not reset.

MMIO registers (offset = `dmem_addr[3:2]`):
- 0 `CON_TX`:
  - Write pushes `dmem_wdata[7:0]`.
  - If the FIFO is full and not popping this cycle, the byte is dropped and `DROP_CNT` increments.
  - Reads return 0.
- 1 `CON_STATUS` (read-only; writes ignored):
  - bit0 = full.
  - bit1 = empty.
  - bits[8+:$clog2(FIFO_DEPTH)+1] = occupancy.
  - All other bits 0.
- 2 `SCRATCH`: plain read/write register, reset value 0.
- 3 `DROP_CNT`:
  - 16-bit counter, zero-extended on read.
  - Saturates at 16'hFFFF.
  - Any write clears it to 0. A clear wins over a same-cycle increment, which cannot occur because both need a write to different offsets.

Unmapped accesses:
- Reads return 0; writes are ignored.
- A write or read sets `bus_err`. The read case uses a registered check of the address each cycle.
- `bus_err` clears only on reset.

Console FIFO:
- Circular buffer with read pointer, write pointer and count. Pointers wrap modulo `FIFO_DEPTH`.
- Output: `con_valid = (count != 0)`, `con_data = mem[rd_ptr]`.
- Pop occurs when `con_valid && con_ready`.
- Push + pop in the same cycle:
  - When full: both happen, the push is accepted, count is unchanged.
  - When empty: push only. No bypass; `con_valid` rises the next cycle.
- `con_data` must stay stable while `con_valid && !con_ready`.

Reset (`reset` low) values:
- `con_valid`=0, `con_data`=0.
- count and pointers = 0.
- `SCRATCH`=0, `DROP_CNT`=0, `bus_err`=0.
- `dmem_rdata` is forced to 0.
- Writes during reset are ignored.
- Reset asserted mid-drain discards the FIFO contents immediately.

## Timing
- Reads: zero latency, combinational from `dmem_addr` to `dmem_rdata`. This matches the single-cycle core.
- Writes: take effect at the rising edge where `dmem_we` is high. A read in the next cycle returns the new value.
- `CON_TX` write at edge N:
  - `con_valid` is high after edge N.
  - `CON_STATUS` read in cycle N+1 shows occupancy +1.
- Pop at edge N: `con_data` shows the next byte after edge N.
- Throughput: one push and one pop per cycle.
- `bus_err`: asserts the cycle after the offending access.

## Structure
- Add to `constants.vh`:
  - MMIO offsets: `MMIO_CON_TX`, `MMIO_CON_STATUS`, `MMIO_SCRATCH`, `MMIO_DROP_CNT`.
  - Status bit positions: `CON_ST_FULL`, `CON_ST_EMPTY`, `CON_ST_CNT_LSB`.
  - `MMIO_BASE` default.
- Sub-module `sync_fifo`, parameterised by width and depth:
  - Inputs: `push`, `pop`, `wdata`.
  - Outputs: `rdata`, `full`, `empty`, `count`.
  - Same async active-low reset.
- Top-level block: decode, RAM, registers, `bus_err`.

## Test plan
- Write 32'hDEADBEEF to 0x40, then read 0x40 the next cycle → `dmem_rdata`=32'hDEADBEEF. Reading 0x42 returns the same word.
- Push bytes 0x41..0x48 with `con_ready`=0 → `CON_STATUS`=32'h0000_0801 (count 8, full). A 9th push → `DROP_CNT`=1 and FIFO unchanged. Raise `con_ready` → 0x41..0x48 drain in order, one per cycle, then `con_valid`=0 and `CON_STATUS` bit1=1.
- FIFO full, `con_ready`=1, `CON_TX` write of 0x5A in the same cycle → no drop, count stays 8, and 0x5A emerges 8th. Continue pushing to force pointer wrap → order is preserved.
- Drive `con_ready` toggling 1010 with `con_valid` high → `con_data` stable in every stalled cycle, and no byte is lost or duplicated.
- Write `SCRATCH`=32'h1234_5678 and fill the FIFO, then pulse `reset` low asynchronously mid-cycle → immediately `con_valid`=0, `SCRATCH`=0, `DROP_CNT`=0, `dmem_rdata`=0 during reset. The RAM word written before reset is retained.
- Write to 0x2000_0000 → `bus_err`=1 the next cycle and stays high. A read of that address returns 0. Write `DROP_CNT` → reads 0 afterwards.
